// File: rtl/eth_tx_framer.sv
// eth_tx_framer: byte-wide 802.3 transmit framer (preamble/SFD, optional pad, FCS, inter-frame gap).
// Build option: define ETH_TX_PAD_EN to zero-pad short frames up to P_MIN_FRAME bytes.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for i_tx_valid; first 0x55 leaves on the start edge
// PRE     | remaining preamble bytes 0x55
// SFD     | emits 0xD5, reinitialises the CRC
// DATA    | accepted bytes go to the wire and the CRC
// PAD     | zero bytes until the minimum length is reached (ETH_TX_PAD_EN)
// FCS     | four bytes of ~crc, least significant byte first
// IFG     | P_IFG silent byte slots
// DISCARD | after an underrun, drops bytes until the frame's last byte
module eth_tx_framer #(
  parameter int P_MIN_FRAME = 60,
  parameter int P_IFG       = 12,
  parameter int P_PREAMBLE  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ce,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic [7:0] o_txd,
  output logic       o_tx_en,
  output logic       o_tx_er,
  output logic       o_underrun,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE     = 3'd1,
    S_SFD     = 3'd2,
    S_DATA    = 3'd3,
`ifdef ETH_TX_PAD_EN
    S_PAD     = 3'd4,
`endif
    S_FCS     = 3'd5,
    S_IFG     = 3'd6,
    S_DISCARD = 3'd7
  } state_t;

  localparam logic [7:0]  PRE_LAST = 8'(P_PREAMBLE - 1);
  localparam logic [7:0]  IFG_LAST = 8'(P_IFG - 1);
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d;
  logic        er_q, er_d;
  logic        underrun_q, underrun_d;
  logic [31:0] fcs_w;

`ifdef ETH_TX_PAD_EN
  localparam logic [10:0] MIN_LEN = 11'(P_MIN_FRAME);
  logic [10:0] len_q, len_d;
  logic [10:0] len_inc;
  assign len_inc = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
`else
  logic unused_min;
  assign unused_min = ^32'(P_MIN_FRAME);
`endif

  // Reflected CRC-32, data bits consumed LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign fcs_w = ~crc_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    txd_d      = txd_q;
    en_d       = en_q;
    er_d       = er_q;
    underrun_d = 1'b0;
`ifdef ETH_TX_PAD_EN
    len_d      = len_q;
`endif
    if (i_ce) begin
      case (state_q)
        S_IDLE: begin
          txd_d = 8'h00;
          en_d  = 1'b0;
          er_d  = 1'b0;
          if (i_tx_valid) begin
            txd_d   = 8'h55;
            en_d    = 1'b1;
            cnt_d   = 8'd1;
            state_d = (PRE_LAST == 8'd0) ? S_SFD : S_PRE;
          end
        end
        S_PRE: begin
          txd_d = 8'h55;
          en_d  = 1'b1;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == PRE_LAST) state_d = S_SFD;
        end
        S_SFD: begin
          txd_d   = 8'hD5;
          en_d    = 1'b1;
          crc_d   = CRC_INIT;
          state_d = S_DATA;
`ifdef ETH_TX_PAD_EN
          len_d   = 11'd0;
`endif
        end
        S_DATA: begin
          if (i_tx_valid) begin
            txd_d = i_tx_data;
            crc_d = crc_byte(crc_q, i_tx_data);
`ifdef ETH_TX_PAD_EN
            len_d = len_inc;
`endif
            if (i_tx_last) begin
              cnt_d   = 8'd0;
`ifdef ETH_TX_PAD_EN
              state_d = (len_inc < MIN_LEN) ? S_PAD : S_FCS;
`else
              state_d = S_FCS;
`endif
            end
          end else begin
            // Upstream starved us: poison the frame on the wire and skip the FCS.
            txd_d      = 8'h00;
            en_d       = 1'b1;
            er_d       = 1'b1;
            underrun_d = 1'b1;
            state_d    = S_DISCARD;
          end
        end
`ifdef ETH_TX_PAD_EN
        S_PAD: begin
          txd_d = 8'h00;
          crc_d = crc_byte(crc_q, 8'h00);
          len_d = len_inc;
          if (len_inc >= MIN_LEN) begin
            cnt_d   = 8'd0;
            state_d = S_FCS;
          end
        end
`endif
        S_FCS: begin
          txd_d = fcs_w[{cnt_q[1:0], 3'b000} +: 8];
          en_d  = 1'b1;
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d   = 8'd0;
            state_d = S_IFG;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_IFG: begin
          txd_d = 8'h00;
          en_d  = 1'b0;
          er_d  = 1'b0;
          if (cnt_q == IFG_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_DISCARD: begin
          txd_d = 8'h00;
          en_d  = 1'b0;
          er_d  = 1'b0;
          if (i_tx_valid && i_tx_last) begin
            cnt_d   = 8'd0;
            state_d = S_IFG;
          end
        end
        default: begin
          txd_d   = 8'h00;
          en_d    = 1'b0;
          er_d    = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      crc_q      <= CRC_INIT;
      txd_q      <= 8'h00;
      en_q       <= 1'b0;
      er_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      txd_q      <= txd_d;
      en_q       <= en_d;
      er_q       <= er_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef ETH_TX_PAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) len_q <= 11'd0;
    else        len_q <= len_d;
  end
`endif

  assign o_tx_ready = i_ce & ((state_q == S_DATA) | (state_q == S_DISCARD));
  assign o_txd      = txd_q;
  assign o_tx_en    = en_q;
  assign o_tx_er    = er_q;
  assign o_underrun = underrun_q;
  assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: frame-level model builds the expected byte-slot stream,
// a single compare process checks every clock; literal checks pin the model.
`timescale 1ns/1ps
module tb_eth_tx_framer;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] txd;
    logic       busy;
    logic       ur;
  } slot_t;

  localparam int    N_PRE  = 7;
  localparam int    N_MIN  = 60;
  localparam int    N_IFG  = 12;
  localparam slot_t IDLE_SLOT = '0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_ce = 1'b1;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       i_tx_last;
  logic       o_tx_ready;
  logic [7:0] o_txd;
  logic       o_tx_en;
  logic       o_tx_er;
  logic       o_underrun;
  logic       o_busy;

  int    n_err = 0;
  int    n_chk = 0;
  int    ce_mode = 0;
  logic  chk_en = 1'b0;
  slot_t exp_q[$];
  bq_t   cap_q;
  slot_t last_e = '0;
  int    run_idle = 0;
  int    last_gap = -1;
  logic  prev_en = 1'b0;
  int    er_cnt = 0;
  int    ur_cnt = 0;

  eth_tx_framer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ce       (i_ce),
    .i_tx_data  (i_tx_data),
    .i_tx_valid (i_tx_valid),
    .i_tx_last  (i_tx_last),
    .o_tx_ready (o_tx_ready),
    .o_txd      (o_txd),
    .o_tx_en    (o_tx_en),
    .o_tx_er    (o_tx_er),
    .o_underrun (o_underrun),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  initial begin : ce_gen
    forever begin
      @(posedge clk);
      #2;
      if (ce_mode == 0) i_ce = 1'b1;
      else              i_ce = ~i_ce;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic slot_t mk(input logic en, input logic er, input logic [7:0] d,
                               input logic busy, input logic ur);
    slot_t s;
    s.en = en; s.er = er; s.txd = d; s.busy = busy; s.ur = ur;
    return s;
  endfunction

  function automatic logic [31:0] crc_ref(input bq_t m);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (m[k]) begin
      c = c ^ {24'h0, m[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Expected slot stream of one frame; ur_idx >= 0 means valid drops before byte ur_idx.
  task automatic push_frame(input bq_t d, input int ur_idx);
    bq_t m;
    logic [31:0] fcs;
    for (int k = 0; k < N_PRE; k++) exp_q.push_back(mk(1'b1, 1'b0, 8'h55, 1'b1, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 8'hD5, 1'b1, 1'b0));
    if (ur_idx < 0) begin
      m = d;
`ifdef ETH_TX_PAD_EN
      while (m.size() < N_MIN) m.push_back(8'h00);
`endif
      foreach (m[k]) exp_q.push_back(mk(1'b1, 1'b0, m[k], 1'b1, 1'b0));
      fcs = ~crc_ref(m);
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b1, 1'b0, fcs[8*k +: 8], 1'b1, 1'b0));
    end else begin
      for (int k = 0; k < ur_idx; k++) exp_q.push_back(mk(1'b1, 1'b0, d[k], 1'b1, 1'b0));
      exp_q.push_back(mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b1));
      for (int k = ur_idx; k < d.size(); k++) exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0));
    end
    for (int k = 0; k < N_IFG; k++)
      exp_q.push_back(mk(1'b0, 1'b0, 8'h00, (k != N_IFG - 1), 1'b0));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_frame(input bq_t d, input int ur_idx, input int abort_after);
    int   i;
    int   g;
    logic acc;
    logic ur_done;
    i = 0;
    ur_done = 1'b0;
    while (i < d.size()) begin
      if (i == ur_idx && !ur_done) begin
        i_tx_valid = 1'b0;
        g = 0;
        do begin
          @(negedge clk);
          acc = i_ce;
          step();
          g++;
        end while (!acc && g < 100);
        ur_done = 1'b1;
      end
      i_tx_data  = d[i];
      i_tx_last  = (i == d.size() - 1);
      i_tx_valid = 1'b1;
      g = 0;
      do begin
        @(negedge clk);
        acc = o_tx_ready & i_tx_valid;
        step();
        g++;
      end while (!acc && g < 200);
      if (!acc) begin
        chk("handshake_timeout", 32'(g), 32'd0);
        return;
      end
      i++;
      if (i == abort_after) return;
    end
  endtask

  task automatic wait_idle(input string nm);
    int g;
    g = 0;
    while ((o_busy || exp_q.size() != 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk({nm, "_idle_timeout"}, 32'(g >= 3000), 32'd0);
    repeat (4) @(negedge clk);
    step();
  endtask

  initial begin : cmp
    slot_t e;
    logic  ce_s;
    logic  r_s;
    forever begin
      @(posedge clk);
      ce_s = i_ce;
      r_s  = rst_n;
      #1;
      if (!r_s || !rst_n) begin
        last_e  = IDLE_SLOT;
        prev_en = 1'b0;
      end else if (chk_en) begin
        if (ce_s) begin
          if (exp_q.size() > 0) e = exp_q.pop_front();
          else                  e = IDLE_SLOT;
          last_e = e;
        end else begin
          e    = last_e;
          e.ur = 1'b0;
        end
        chk(ce_s ? "slot" : "hold", {20'h0, o_tx_en, o_tx_er, o_txd, o_busy, o_underrun},
            {20'h0, e});
        if (ce_s) begin
          if (o_tx_en) begin
            cap_q.push_back(o_txd);
            if (!prev_en) last_gap = run_idle;
            run_idle = 0;
          end else begin
            run_idle++;
          end
          prev_en = o_tx_en;
          if (o_tx_er) er_cnt++;
        end
        if (o_underrun) ur_cnt++;
      end
    end
  end

  initial begin : watchdog
    #600000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : main
    bq_t d, d2;
    int  z;
    int  er0, ur0;
    rst_n      = 1'b0;
    i_tx_valid = 1'b0;
    i_tx_last  = 1'b0;
    i_tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_txd",   32'(o_txd),      32'h0);
    chk("rst_en",    32'(o_tx_en),    32'h0);
    chk("rst_er",    32'(o_tx_er),    32'h0);
    chk("rst_ur",    32'(o_underrun), 32'h0);
    chk("rst_busy",  32'(o_busy),     32'h0);
    chk("rst_ready", 32'(o_tx_ready), 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();
    chk("idle_ready", 32'(o_tx_ready), 32'h0);

    // 60-byte frame, continuous ce
    d = {};
    for (int k = 0; k < 60; k++) d.push_back(8'(k * 7 + 3));
    cap_q = {};
    push_frame(d, -1);
    drive_frame(d, -1, -1);
    i_tx_valid = 1'b0;
    wait_idle("t1");
    chk("t1_en_slots", 32'(cap_q.size()), 32'd72);
    if (cap_q.size() >= 9) begin
      chk("t1_pre0", 32'(cap_q[0]), 32'h55);
      chk("t1_pre6", 32'(cap_q[6]), 32'h55);
      chk("t1_sfd",  32'(cap_q[7]), 32'hD5);
      chk("t1_d0",   32'(cap_q[8]), 32'h03);
    end

    // "123456789": standard check value, or padding to 60 bytes
    d = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    cap_q = {};
    push_frame(d, -1);
    drive_frame(d, -1, -1);
    i_tx_valid = 1'b0;
    wait_idle("t2");
`ifdef ETH_TX_PAD_EN
    chk("t3_en_slots", 32'(cap_q.size()), 32'd72);
    z = 0;
    if (cap_q.size() >= 68) for (int k = 17; k < 68; k++) if (cap_q[k] == 8'h00) z++;
    chk("t3_pad_zeros", 32'(z), 32'd51);
`else
    chk("t2_en_slots", 32'(cap_q.size()), 32'd21);
    if (cap_q.size() >= 21) begin
      chk("t2_fcs0", 32'(cap_q[17]), 32'h26);
      chk("t2_fcs1", 32'(cap_q[18]), 32'h39);
      chk("t2_fcs2", 32'(cap_q[19]), 32'hF4);
      chk("t2_fcs3", 32'(cap_q[20]), 32'hCB);
    end
`endif

    // back-to-back frames, valid held high between them
    d = {};
    d2 = {};
    for (int k = 0; k < 64; k++) d.push_back(8'(255 - k));
    for (int k = 0; k < 61; k++) d2.push_back(8'(k ^ 8'hA5));
    push_frame(d, -1);
    push_frame(d2, -1);
    drive_frame(d, -1, -1);
    drive_frame(d2, -1, -1);
    i_tx_valid = 1'b0;
    wait_idle("t4");
    chk("t4_gap", 32'(last_gap), 32'd12);

    // underrun after byte 20 of 64
    d = {};
    for (int k = 0; k < 64; k++) d.push_back(8'(k + 16));
    cap_q = {};
    er0 = er_cnt;
    ur0 = ur_cnt;
    push_frame(d, 20);
    drive_frame(d, 20, -1);
    i_tx_valid = 1'b0;
    wait_idle("t5");
    chk("t5_er_slots", 32'(er_cnt - er0), 32'd1);
    chk("t5_ur_pulses", 32'(ur_cnt - ur0), 32'd1);
    chk("t5_en_slots", 32'(cap_q.size()), 32'd29);

    // ce 1-in-2, then async reset in the middle of DATA
    ce_mode = 1;
    d = {};
    for (int k = 0; k < 64; k++) d.push_back(8'(k * 3));
    push_frame(d, -1);
    drive_frame(d, -1, 10);
    chk("t6_mid_en", 32'(o_tx_en), 32'h1);
    @(negedge clk);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("t6_rst_en",   32'(o_tx_en), 32'h0);
    chk("t6_rst_busy", 32'(o_busy),  32'h0);
    chk("t6_rst_txd",  32'(o_txd),   32'h0);
    exp_q.delete();
    i_tx_valid = 1'b0;
    i_tx_last  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n   = 1'b1;
    chk_en  = 1'b1;
    ce_mode = 0;
    step();
    step();

    // recovery frame after reset
    d = {};
    for (int k = 0; k < 12; k++) d.push_back(8'(8'hC0 + k));
    push_frame(d, -1);
    drive_frame(d, -1, -1);
    i_tx_valid = 1'b0;
    wait_idle("t7");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
